// File: rtl/square_channel_gen.sv
// Square-wave sound channel: frequency timer, duty sequencer, length counter,
// volume envelope and optional frequency sweep, all clocked by system_clock.
// Frame-rate events come from an internal 3-bit step counter advanced by the
// 512 Hz frame_tick strobe.
module square_channel_gen #(
  parameter int OUT_W     = 24,
  parameter int VOL_SHIFT = 16,
  parameter int SWEEP_EN  = 1,
  parameter int PRESCALE  = 16
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [7:0]              NRx0,
  input  logic [7:0]              NRx1,
  input  logic [7:0]              NRx2,
  input  logic [7:0]              NRx3,
  input  logic [7:0]              NRx4,
  input  logic                    trigger,
  input  logic                    length_load,
  output logic signed [OUT_W-1:0] output_wave,
  output logic                    channel_on
);

  // Wide enough to hold the longest reload, 2048 * PRESCALE.
  localparam int TIMER_W = $clog2(2048 * PRESCALE + 1);

  // Reload value of the frequency timer for an 11-bit frequency code.
  function automatic logic [TIMER_W-1:0] reload_of(input logic [10:0] f);
    logic [11:0] units;
    units = 12'd2048 - {1'b0, f};
    return TIMER_W'(units) * TIMER_W'(PRESCALE);
  endfunction

  // One sweep step; bit 11 of the result flags an overflow past 2047.
  function automatic logic [11:0] sweep_calc(input logic [10:0] base,
                                             input logic        neg,
                                             input logic [2:0]  sh);
    logic [11:0] delta;
    delta = {1'b0, base >> sh};
    return neg ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
  endfunction

  logic [2:0]               step_reg, step_next;
  logic [TIMER_W-1:0]       timer_reg, timer_next;
  logic [2:0]               duty_pos_reg, duty_pos_next;
  logic [6:0]               length_reg, length_next;
  logic [3:0]               vol_reg, vol_next;
  logic [2:0]               env_timer_reg, env_timer_next;
  logic [10:0]              shadow_reg, shadow_next;
  logic [3:0]               sweep_timer_reg, sweep_timer_next;
  logic                     sweep_en_reg, sweep_en_next;
  logic                     channel_on_reg, channel_on_next;
  logic signed [OUT_W-1:0]  output_wave_reg, output_wave_next;

  logic [10:0]              freq;
  logic [10:0]              timer_f;
  logic [2:0]               sw_period;
  logic [2:0]               sw_shift;
  logic                     sw_neg;
  logic [2:0]               env_period;
  logic                     env_up;
  logic                     dac_on;
  logic                     seq_tick;
  logic                     len_clk;
  logic                     sweep_clk;
  logic                     env_clk;
  logic                     len_expire;
  logic                     sweep_ovf;
  logic [11:0]              sweep_new;
  logic [11:0]              sweep_chk;
  logic [7:0]               pattern;
  logic                     duty_bit;
  logic signed [OUT_W-1:0]  magnitude;
  logic                     unused_bits;

  assign freq       = {NRx4[2:0], NRx3};
  assign sw_period  = NRx0[6:4];
  assign sw_neg     = NRx0[3];
  assign sw_shift   = NRx0[2:0];
  assign env_period = NRx2[2:0];
  assign env_up     = NRx2[3];
  assign dac_on     = (NRx2[7:3] != 5'd0);
  assign timer_f    = (SWEEP_EN != 0) ? shadow_reg : freq;
  assign unused_bits = ^{NRx4[7], NRx4[5:3], NRx0[7]};

  // A trigger in the same cycle as frame_tick suppresses all frame clocks.
  assign seq_tick  = frame_tick && !trigger;
  assign len_clk   = seq_tick && !step_reg[0];
  assign sweep_clk = seq_tick && (step_reg[1:0] == 2'b10);
  assign env_clk   = seq_tick && (step_reg == 3'd7);

  // Next-state logic for every counter and the registered sample.
  always_comb begin
    step_next        = step_reg + {2'b00, frame_tick};
    timer_next       = timer_reg;
    duty_pos_next    = duty_pos_reg;
    length_next      = length_reg;
    vol_next         = vol_reg;
    env_timer_next   = env_timer_reg;
    shadow_next      = shadow_reg;
    sweep_timer_next = sweep_timer_reg;
    sweep_en_next    = sweep_en_reg;
    channel_on_next  = channel_on_reg;
    output_wave_next = '0;
    len_expire       = 1'b0;
    sweep_ovf        = 1'b0;
    sweep_new        = '0;
    sweep_chk        = '0;
    pattern          = 8'b01111110;
    duty_bit         = 1'b0;
    magnitude        = '0;

    // Frequency timer; on trigger the shadow is being loaded with freq.
    if (trigger) begin
      timer_next    = reload_of(freq);
      duty_pos_next = 3'd0;
    end else if (timer_reg == TIMER_W'(1)) begin
      timer_next    = reload_of(timer_f);
      duty_pos_next = duty_pos_reg + 3'd1;
    end else if (timer_reg != '0) begin
      timer_next = timer_reg - TIMER_W'(1);
    end

    // Length counter: a length write lands first, then the trigger rule.
    if (length_load) begin
      length_next = 7'd64 - {1'b0, NRx1[5:0]};
    end
    if (trigger) begin
      if (length_next == 7'd0) begin
        length_next = 7'd64;
      end
    end else if (len_clk && NRx4[6] && (length_next != 7'd0)) begin
      length_next = length_next - 7'd1;
      if (length_next == 7'd0) begin
        len_expire = 1'b1;
      end
    end

    // Volume envelope, saturating at 0 and 15; period 0 freezes volume.
    if (trigger) begin
      vol_next       = NRx2[7:4];
      env_timer_next = env_period;
    end else if (env_clk && (env_period != 3'd0)) begin
      if (env_timer_reg <= 3'd1) begin
        env_timer_next = env_period;
        if (env_up && (vol_reg != 4'd15)) begin
          vol_next = vol_reg + 4'd1;
        end else if (!env_up && (vol_reg != 4'd0)) begin
          vol_next = vol_reg - 4'd1;
        end
      end else begin
        env_timer_next = env_timer_reg - 3'd1;
      end
    end

    // Frequency sweep on the shadow register; a sweep period of 0 counts as 8.
    if (SWEEP_EN != 0) begin
      if (trigger) begin
        shadow_next      = freq;
        sweep_timer_next = (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
        sweep_en_next    = (sw_period != 3'd0) || (sw_shift != 3'd0);
        if (sw_shift != 3'd0) begin
          sweep_chk = sweep_calc(freq, sw_neg, sw_shift);
          sweep_ovf = sweep_chk[11];
        end
      end else if (sweep_clk) begin
        if (sweep_timer_reg <= 4'd1) begin
          sweep_timer_next = (sw_period == 3'd0) ? 4'd8 : {1'b0, sw_period};
          if (sweep_en_reg && (sw_period != 3'd0)) begin
            sweep_new = sweep_calc(shadow_reg, sw_neg, sw_shift);
            if (sweep_new[11]) begin
              sweep_ovf = 1'b1;
            end else if (sw_shift != 3'd0) begin
              shadow_next = sweep_new[10:0];
              sweep_chk   = sweep_calc(sweep_new[10:0], sw_neg, sw_shift);
              sweep_ovf   = sweep_chk[11];
            end
          end
        end else begin
          sweep_timer_next = sweep_timer_reg - 4'd1;
        end
      end
    end

    // Channel status: trigger beats length expiry; overflow and DAC-off beat all.
    if (trigger) begin
      channel_on_next = dac_on;
    end else if (len_expire) begin
      channel_on_next = 1'b0;
    end
    if (sweep_ovf || !dac_on) begin
      channel_on_next = 1'b0;
    end

    // Output sample from the current (registered) state.
    case (NRx1[7:6])
      2'b00:   pattern = 8'b00000001;
      2'b01:   pattern = 8'b10000001;
      2'b10:   pattern = 8'b10000111;
      default: pattern = 8'b01111110;
    endcase
    duty_bit  = pattern[duty_pos_reg];
    magnitude = OUT_W'(vol_reg) << VOL_SHIFT;
    if (channel_on_reg) begin
      output_wave_next = duty_bit ? magnitude : -magnitude;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      step_reg        <= '0;
      timer_reg       <= '0;
      duty_pos_reg    <= '0;
      length_reg      <= '0;
      vol_reg         <= '0;
      env_timer_reg   <= '0;
      shadow_reg      <= '0;
      sweep_timer_reg <= '0;
      sweep_en_reg    <= 1'b0;
      channel_on_reg  <= 1'b0;
      output_wave_reg <= '0;
    end else begin
      step_reg        <= step_next;
      timer_reg       <= timer_next;
      duty_pos_reg    <= duty_pos_next;
      length_reg      <= length_next;
      vol_reg         <= vol_next;
      env_timer_reg   <= env_timer_next;
      shadow_reg      <= shadow_next;
      sweep_timer_reg <= sweep_timer_next;
      sweep_en_reg    <= sweep_en_next;
      channel_on_reg  <= channel_on_next;
      output_wave_reg <= output_wave_next;
    end
  end

  assign output_wave = output_wave_reg;
  assign channel_on  = channel_on_reg;

endmodule

// File: tb/tb_square_channel_gen.sv
// Directed bench for square_channel_gen with default parameters
// (OUT_W 24, VOL_SHIFT 16, SWEEP_EN 1, PRESCALE 16).
module tb_square_channel_gen;

  logic               system_clock = 1'b0;
  logic               reset        = 1'b1;
  logic               frame_tick   = 1'b0;
  logic [7:0]         NRx0 = 8'h00;
  logic [7:0]         NRx1 = 8'h00;
  logic [7:0]         NRx2 = 8'h00;
  logic [7:0]         NRx3 = 8'h00;
  logic [7:0]         NRx4 = 8'h00;
  logic               trigger      = 1'b0;
  logic               length_load  = 1'b0;
  logic signed [23:0] output_wave;
  logic               channel_on;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] POS = 32'h000F_0000;
  localparam logic [31:0] NEG = 32'hFFF1_0000;

  square_channel_gen #(
    .OUT_W(24), .VOL_SHIFT(16), .SWEEP_EN(1), .PRESCALE(16)
  ) dut (
    .system_clock(system_clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .NRx0(NRx0),
    .NRx1(NRx1),
    .NRx2(NRx2),
    .NRx3(NRx3),
    .NRx4(NRx4),
    .trigger(trigger),
    .length_load(length_load),
    .output_wave(output_wave),
    .channel_on(channel_on)
  );

  always #5 system_clock = ~system_clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("%0t check %s ok value=%h", $time, tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1);
    trigger = 1'b0;
  endtask

  task automatic frames(input int n);
    frame_tick = 1'b1;
    tick(n);
    frame_tick = 1'b0;
  endtask

  function automatic logic [31:0] mag(input logic signed [23:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return (w < 0) ? -w : w;
  endfunction

  initial begin
    logic [7:0]  pat;
    logic [23:0] held;
    int          bad;
    int          lvl;

    // Reset state, then a long idle stretch.
    tick(2);
    reset = 1'b0;
    chk("reset_chan", 32'(channel_on), 32'd0);
    chk("reset_out", output_wave, 32'd0);
    bad = 0;
    repeat (1000) begin
      tick(1);
      if (output_wave !== 24'd0 || channel_on !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Duty 10 at freq 2047: one duty step per 16 cycles, +/-0x0F0000.
    NRx3 = 8'hFF; NRx4 = 8'h07; NRx1 = 8'h80; NRx2 = 8'hF0; NRx0 = 8'h00;
    pulse_trigger();
    chk("duty_chan_on", 32'(channel_on), 32'd1);
    chk("duty_latency", output_wave, 32'd0);
    pat = 8'b10000111;
    tick(1);
    chk("duty_pos0", output_wave, pat[0] ? POS : NEG);
    for (int n = 1; n <= 8; n++) begin
      tick(16);
      chk($sformatf("duty_pos%0d", n % 8), output_wave, pat[n % 8] ? POS : NEG);
    end

    // Envelope up from 1 with period 1, saturating at 15.
    NRx2 = 8'h19;
    pulse_trigger();
    for (int k = 1; k <= 16; k++) begin
      frames(8);
      tick(1);
      lvl = (k + 1 > 15) ? 15 : k + 1;
      chk($sformatf("env_clk%0d", k), mag(output_wave), 32'(lvl) << 16);
    end
    NRx2 = 8'h07;
    tick(1);
    chk("dac_off_chan", 32'(channel_on), 32'd0);
    tick(1);
    chk("dac_off_out", output_wave, 32'd0);

    // Length 64-62 = 2 expires at the second length clock (step 2).
    NRx2 = 8'hF0; NRx1 = 8'hBE; NRx4 = 8'h47;
    length_load = 1'b1;
    tick(1);
    length_load = 1'b0;
    pulse_trigger();
    chk("len_trig_on", 32'(channel_on), 32'd1);
    frames(1);
    chk("len_step0", 32'(channel_on), 32'd1);
    frames(1);
    chk("len_step1", 32'(channel_on), 32'd1);
    frames(1);
    chk("len_step2_chan", 32'(channel_on), 32'd0);
    chk("len_step2_out", mag(output_wave), POS);
    tick(1);
    chk("len_out_zero", output_wave, 32'd0);

    // Collision: trigger with frame_tick at step 6, length = 1.
    NRx4 = 8'h07;
    frames(3);
    NRx4 = 8'h47; NRx1 = 8'hBF;
    length_load = 1'b1;
    tick(1);
    length_load = 1'b0;
    trigger = 1'b1; frame_tick = 1'b1;
    tick(1);
    trigger = 1'b0; frame_tick = 1'b0;
    chk("coll_chan", 32'(channel_on), 32'd1);
    frames(1);
    chk("coll_step7", 32'(channel_on), 32'd1);
    frames(1);
    chk("coll_step0_len", 32'(channel_on), 32'd0);

    // Sweep overflow at trigger: 0x7F0 + 0x3F8 > 2047.
    NRx4 = 8'h07; NRx3 = 8'hF0; NRx0 = 8'h00;
    pulse_trigger();
    chk("sw_plain_on", 32'(channel_on), 32'd1);
    NRx0 = 8'h11;
    pulse_trigger();
    chk("sw_trig_ovf", 32'(channel_on), 32'd0);

    // Sweep add shift 7: 2032+15 = 2047 fits, re-check 2047+15 overflows.
    NRx0 = 8'h17;
    pulse_trigger();
    chk("sw_add_on", 32'(channel_on), 32'd1);
    frames(1);
    chk("sw_add_step1", 32'(channel_on), 32'd1);
    frames(1);
    chk("sw_add_step2", 32'(channel_on), 32'd0);

    // Sweep subtract shift 1: 2044 -> 1022 at step 6, period becomes 16416.
    NRx0 = 8'h19; NRx3 = 8'hFC; NRx4 = 8'h07; NRx1 = 8'h80;
    pulse_trigger();
    chk("sw_sub_on", 32'(channel_on), 32'd1);
    frames(4);
    tick(80);
    chk("sw_sub_chan", 32'(channel_on), 32'd1);
    chk("sw_sub_mag", mag(output_wave), POS);
    held = output_wave;
    bad = 0;
    repeat (600) begin
      tick(1);
      if (output_wave !== held) bad++;
    end
    chk("sw_sub_slow", bad, 0);

    // Reset mid-note wins over trigger and frame_tick.
    reset = 1'b1; trigger = 1'b1; frame_tick = 1'b1;
    tick(1);
    reset = 1'b0; trigger = 1'b0; frame_tick = 1'b0;
    chk("rst_mid_chan", 32'(channel_on), 32'd0);
    chk("rst_mid_out", output_wave, 32'd0);
    tick(1);
    chk("rst_mid_out2", output_wave, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
